// File: rtl/temp_scan_scheduler.sv
// rtl/temp_scan_scheduler.sv - round-robin temperature scan scheduler with shared shift-add datapath
module temp_scan_scheduler #(
  parameter int ALARM_HYST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] sensor_value,
  input  logic [4:0]  factory_base_temp,
  input  logic [3:0]  factory_temp_coef,
  input  logic [7:0]  alarm_threshold,
  output logic [3:0]  ack,
  output logic        temp_valid,
  output logic [1:0]  temp_channel,
  output logic [7:0]  temperature,
  output logic [3:0]  alarm,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

  localparam logic [7:0] HYST = 8'(ALARM_HYST);

  state_t      state, state_nxt;
  logic [1:0]  step;
  logic [1:0]  rr_ptr;
  logic [1:0]  granted;
  logic [1:0]  grant_idx;
  logic        grant_found;
  logic [3:0]  op_sensor;
  logic [3:0]  op_coef;
  logic [4:0]  op_base;
  logic [7:0]  acc;
  logic [7:0]  temp_sum;
  logic [7:0]  clear_level;

  // First requester at or after rr_ptr, wrapping 3 -> 0.
  always_comb begin
    grant_idx   = rr_ptr;
    grant_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!grant_found && req[rr_ptr + 2'(k)]) begin
        grant_idx   = rr_ptr + 2'(k);
        grant_found = 1'b1;
      end
    end
  end

  assign temp_sum    = {3'b000, op_base} + {3'b000, acc[7:3]};
  assign clear_level = (alarm_threshold > HYST) ? (alarm_threshold - HYST) : 8'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 4'b0000) state_nxt = MUL;
      MUL:     if (step == 2'd3) state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      step         <= 2'd0;
      rr_ptr       <= 2'd0;
      granted      <= 2'd0;
      op_sensor    <= 4'd0;
      op_coef      <= 4'd0;
      op_base      <= 5'd0;
      acc          <= 8'd0;
      temperature  <= 8'd0;
      temp_channel <= 2'd0;
      alarm        <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            granted   <= grant_idx;
            op_sensor <= sensor_value[{grant_idx, 2'b00} +: 4];
            op_coef   <= factory_temp_coef;
            op_base   <= factory_base_temp;
            acc       <= 8'd0;
            step      <= 2'd0;
          end
        end
        MUL: begin
          if (op_coef[step]) acc <= acc + ({4'b0000, op_sensor} << step);
          step <= step + 2'd1;
        end
        ADD: begin
          temperature  <= temp_sum;
          temp_channel <= granted;
          // Between the clear level and the threshold the flag keeps its value.
          if (temp_sum >= alarm_threshold)  alarm[granted] <= 1'b1;
          else if (temp_sum < clear_level)  alarm[granted] <= 1'b0;
        end
        DONE: begin
          rr_ptr <= granted + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign ack        = (state == DONE) ? (4'b0001 << granted) : 4'b0000;
  assign temp_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_temp_scan_scheduler.sv
// tb/tb_temp_scan_scheduler.sv - scoreboard bench for temp_scan_scheduler
module tb_temp_scan_scheduler;

  localparam int HYST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] sensor_value = 16'd0;
  logic [4:0]  factory_base_temp = 5'd0;
  logic [3:0]  factory_temp_coef = 4'd0;
  logic [7:0]  alarm_threshold = 8'd255;
  logic [3:0]  ack;
  logic        temp_valid;
  logic [1:0]  temp_channel;
  logic [7:0]  temperature;
  logic [3:0]  alarm;
  logic        busy;

  temp_scan_scheduler #(.ALARM_HYST(HYST)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .sensor_value      (sensor_value),
    .factory_base_temp (factory_base_temp),
    .factory_temp_coef (factory_temp_coef),
    .alarm_threshold   (alarm_threshold),
    .ack               (ack),
    .temp_valid        (temp_valid),
    .temp_channel      (temp_channel),
    .temperature       (temperature),
    .alarm             (alarm),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] temp;
    logic [3:0] alarm;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] model_alarm = 4'd0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: temperature formula plus hysteresis alarm state per channel.
  task automatic push_exp(input logic [1:0] ch, input logic [3:0] sv, input logic [4:0] b,
                          input logic [3:0] c, input logic [7:0] thr);
    int   t;
    int   clr;
    exp_t e;
    t   = int'(b) + ((int'(c) * int'(sv)) >> 3);
    clr = (int'(thr) > HYST) ? int'(thr) - HYST : 0;
    if (t >= int'(thr))  model_alarm[ch] = 1'b1;
    else if (t < clr)    model_alarm[ch] = 1'b0;
    e.ch    = ch;
    e.temp  = 8'(t);
    e.alarm = model_alarm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && temp_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 32'(temp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("temperature", 32'(temperature), 32'(mon_e.temp));
        check_eq("temp_channel", 32'(temp_channel), 32'(mon_e.ch));
        check_eq("ack", 32'(ack), 32'(4'b0001 << mon_e.ch));
        check_eq("alarm", 32'(alarm), 32'(mon_e.alarm));
      end
    end else if (rst_n && ack != 4'd0) begin
      check_eq("stray_ack", 32'(ack), 32'd0);
    end
  end

  // Called just after the capture edge; returns edges until temp_valid and busy cycles seen.
  task automatic wait_result(input bit chg, input logic [3:0] nsv, input logic [3:0] nc,
                             output int edges, output int busy_cnt);
    bit got;
    got = 1'b0;
    edges = 0;
    busy_cnt = 0;
    @(negedge clk);
    if (busy) busy_cnt++;
    while (!got && edges < 20) begin
      @(posedge clk);
      edges++;
      if (chg && edges == 1) begin
        #1;
        sensor_value[3:0] = nsv;
        factory_temp_coef = nc;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (temp_valid) got = 1'b1;
    end
    check_eq("result_seen", 32'(got), 32'd1);
  endtask

  task automatic run_conv(input logic [1:0] ch, input logic [3:0] sv, input logic [4:0] b,
                          input logic [3:0] c, input logic [7:0] thr,
                          input bit chg, input logic [3:0] nsv, input logic [3:0] nc);
    int edges;
    int bc;
    @(negedge clk);
    sensor_value[{ch, 2'b00} +: 4] = sv;
    factory_base_temp = b;
    factory_temp_coef = c;
    alarm_threshold   = thr;
    req = 4'b0001 << ch;
    push_exp(ch, sv, b, c, thr);
    @(posedge clk);
    #1 req = 4'd0;
    wait_result(chg, nsv, nc, edges, bc);
    check_eq("latency", 32'(edges), 32'd5);
    check_eq("busy_cycles", 32'(bc), 32'd6);
    @(negedge clk);
    check_eq("valid_one_cycle", 32'(temp_valid), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_alarm = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int last;
    int edges;
    int bc;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_valid", 32'(temp_valid), 32'd0);
    check_eq("rst_temp", 32'(temperature), 32'd0);
    check_eq("rst_chan", 32'(temp_channel), 32'd0);
    check_eq("rst_alarm", 32'(alarm), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Basic conversion and extremes.
    run_conv(2'd0, 4'd12, 5'd20, 4'd5, 8'd255, 1'b0, 4'd0, 4'd0);
    run_conv(2'd3, 4'd15, 5'd31, 4'd15, 8'd255, 1'b0, 4'd0, 4'd0);
    run_conv(2'd1, 4'd9, 5'd0, 4'd0, 8'd255, 1'b0, 4'd0, 4'd0);
    run_conv(2'd2, 4'd7, 5'd7, 4'd1, 8'd255, 1'b0, 4'd0, 4'd0);

    // Round-robin with all requests held.
    do_reset();
    sensor_value      = 16'h4321;
    factory_temp_coef = 4'd8;
    factory_base_temp = 5'd0;
    alarm_threshold   = 8'd255;
    for (int k = 0; k < 5; k++) push_exp(2'(k % 4), 4'(k % 4 + 1), 5'd0, 4'd8, 8'd255);
    req = 4'hF;
    n = 0;
    last = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      if (temp_valid) begin
        if (n > 0) check_eq("rr_gap", 32'(cyc - last), 32'd7);
        last = cyc;
        n++;
        if (n == 5) req = 4'd0;
      end
    end
    check_eq("rr_count", 32'(n), 32'd5);
    repeat (2) @(negedge clk);
    check_eq("rr_idle", 32'(busy), 32'd0);

    // Alarm hysteresis on ch1 with ch3 alarm set beforehand.
    run_conv(2'd3, 4'd0, 5'd31, 4'd0, 8'd30, 1'b0, 4'd0, 4'd0);
    run_conv(2'd1, 4'd0, 5'd30, 4'd0, 8'd30, 1'b0, 4'd0, 4'd0);
    run_conv(2'd1, 4'd0, 5'd29, 4'd0, 8'd30, 1'b0, 4'd0, 4'd0);
    run_conv(2'd1, 4'd0, 5'd28, 4'd0, 8'd30, 1'b0, 4'd0, 4'd0);
    run_conv(2'd1, 4'd0, 5'd27, 4'd0, 8'd30, 1'b0, 4'd0, 4'd0);
    check_eq("alarm_final", 32'(alarm), 32'b1000);

    // Reset during the second MUL cycle, then re-service of ch2.
    @(negedge clk);
    sensor_value[11:8] = 4'd10;
    factory_base_temp  = 5'd5;
    factory_temp_coef  = 4'd3;
    alarm_threshold    = 8'd255;
    req = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_ack", 32'(ack), 32'd0);
    check_eq("abort_valid", 32'(temp_valid), 32'd0);
    check_eq("abort_temp", 32'(temperature), 32'd0);
    check_eq("abort_chan", 32'(temp_channel), 32'd0);
    check_eq("abort_alarm", 32'(alarm), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    model_alarm = 4'd0;
    rst_n = 1'b1;
    push_exp(2'd2, 4'd10, 5'd5, 4'd3, 8'd255);
    @(posedge clk);
    #1 req = 4'd0;
    wait_result(1'b0, 4'd0, 4'd0, edges, bc);
    check_eq("abort_latency", 32'(edges), 32'd5);

    // Operand freeze, then new operands take effect.
    run_conv(2'd0, 4'd12, 5'd20, 4'd5, 8'd255, 1'b1, 4'd3, 4'd1);
    run_conv(2'd0, 4'd3, 5'd20, 4'd1, 8'd255, 1'b0, 4'd0, 4'd0);

    repeat (10) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_scan_scheduler.md
# temp_scan_scheduler

Sequential scheduler that shares one temperature-calculation datapath among four sensor channels. It arbitrates channel requests round-robin and captures the granted channel's 4-bit sensor value together with the factory calibration. It computes temperature = factoryBaseTemp + ((factoryTempCoef × sensor) >> 3) with a 4-step serial shift-add multiplier, then returns the result with a per-channel ack. It sits between the per-sensor sampling front ends and the display/alarm logic, and keeps per-channel over-temperature alarm flags with hysteresis.

## Interface

- ALARM_HYST, default 2: hysteresis in degrees; an alarm clears only when the temperature is below threshold − ALARM_HYST (floor 0).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  4  per-channel level request; bit i = channel i.
- sensor_value  in  16  channel i sensor value on bits [4i+3:4i].
- factory_base_temp  in  5  unsigned base temperature.
- factory_temp_coef  in  4  unsigned coefficient.
- alarm_threshold  in  8  unsigned alarm set threshold.
- ack  out  4  one-hot, one-cycle pulse for the channel whose result is issued.
- temp_valid  out  1  result valid, one cycle.
- temp_channel  out  2  channel of the current result.
- temperature  out  8  result.
- alarm  out  4  per-channel alarm flags, level.
- busy  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, MUL, ADD, DONE.
- IDLE: if req != 0, grant the first requesting channel at or after rr_ptr, scanning upward and wrapping from 3 to 0.
  - Capture that channel's sensor value, the coefficient and the base into operand registers.
  - Clear the accumulator and the step count, then go to MUL.
  - If req == 0, stay in IDLE.
- MUL: four steps, i = 0..3.
  - If coef bit i is 1, acc += sensor << i; acc is 8 bits.
  - After step 3, go to ADD.
- ADD:
  - temperature = {3'b0, base} + {3'b0, acc[7:3]}.
  - Maximum value is 31 + 28 = 59, so there is never a carry out.
  - Also latch temp_channel and update alarm[granted].
  - Go to DONE.
- DONE:
  - temp_valid = 1 and ack[granted] = 1.
  - rr_ptr = granted + 1 (mod 4).
  - Go to IDLE.
- Alarm rule, applied at the ADD edge for the granted channel only:
  - Set when temperature ≥ alarm_threshold.
  - Clear when temperature < max(alarm_threshold − ALARM_HYST, 0).
  - Otherwise hold.
- Operands are frozen once captured. Changes to sensor_value, coef or base during a conversion have no effect on that conversion. alarm_threshold is sampled at the ADD edge.
- If req is dropped mid-conversion, the conversion still completes and ack still pulses.
- A req held high after its ack counts as a new request.

## Timing

- Reset: when rst_n is low at an edge, the block goes to IDLE and clears everything.
  - ack, temp_valid, temp_channel, temperature, alarm and busy all go to 0.
  - rr_ptr goes to 0 and the accumulator is cleared.
  - An aborted conversion produces no ack.
- Capture edge E0 (state IDLE, req != 0):
  - MUL occupies the cycles after edges E0 through E3.
  - ADD is the cycle after E4.
  - DONE is the cycle after E5; temp_valid, ack, temperature and alarm are visible then.
- Latency from capture edge to result visible: 5 cycles.
- State is IDLE again after E6. The earliest next capture is E7, giving one result per 7 cycles.
- temperature and temp_channel hold their values until the next ADD edge. temp_valid and ack are high only in DONE.
- busy is high from the cycle after E0 through DONE.
- Requester rule: to avoid re-service, drop req by the edge that ends DONE.

## Test plan

- Basic conversion: base=20, coef=5, sensor ch0=12, req=0001.
  - Required: 60>>3=7, so temperature=27, temp_channel=0.
  - ack=0001 and temp_valid for exactly one cycle, 5 cycles after the capture edge; busy high for 6 cycles.
- Extremes:
  - base=31, coef=15, sensor=15 → temperature=59.
  - base=0, coef=0, sensor=9 → 0.
  - base=7, coef=1, sensor=7 → 7 (7>>3=0).
- Round-robin with req=1111 held continuously (distinct sensor values 1,2,3,4; coef=8; base=0):
  - Results in channel order 0,1,2,3,0 with temperatures 1,2,3,4,1.
  - Results arrive 7 cycles apart.
- Alarm hysteresis on ch1, threshold=30, ALARM_HYST=2:
  - Sequence temp 30 → alarm[1]=1; temp 29 → stays 1; temp 28 → stays 1; temp 27 → 0.
  - Other alarm bits unchanged.
- Mid-conversion reset: req=0100, drive rst_n low for one edge during the second MUL cycle.
  - Required: all outputs 0 next cycle and no ack.
  - After release with req=0100 still high: ch2 is served and the result appears 5 cycles after the new capture.
- Operand freeze: change sensor ch0 from 12 to 3 and coef from 5 to 1 during MUL.
  - Required: result still 27 (base=20).
  - Next conversion uses the new values: 20+0=20.
